// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with parallel load, wrap/saturate ends and a
// combinational terminal count. Define UPDN_CNT_STATUS_EN to add sticky ovf/unf flags.
module updown_mod_counter #(
    parameter int N        = 4,
    parameter int MOD      = 16,
    parameter int SATURATE = 0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         dir,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         clr_status,
    output logic [N-1:0] out,
    output logic         tc,
    output logic         ovf,
    output logic         unf
);

    localparam logic [N-1:0] MAX_VAL = N'(MOD - 1);

    logic [N-1:0] r_cnt;
    logic [N-1:0] w_cnt_nxt;
    logic [N-1:0] w_load_clamped;
    logic         w_at_max;
    logic         w_at_min;

    assign w_at_max       = (r_cnt == MAX_VAL);
    assign w_at_min       = (r_cnt == '0);
    assign w_load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (load) begin
            w_cnt_nxt = w_load_clamped;
        end else if (en) begin
            if (!dir) begin
                if (!w_at_max) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else if (SATURATE == 0) begin
                    w_cnt_nxt = '0;
                end
            end else begin
                if (!w_at_min) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (SATURATE == 0) begin
                    w_cnt_nxt = MAX_VAL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign out = r_cnt;
    // Purely combinational so a following stage can use it as its enable on the same edge.
    assign tc  = en & ~load & ((~dir & w_at_max) | (dir & w_at_min));

`ifdef UPDN_CNT_STATUS_EN
    logic r_ovf;
    logic r_unf;

    // A terminal event on the same edge as clr_status keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (tc && !dir) begin
                r_ovf <= 1'b1;
            end else if (clr_status) begin
                r_ovf <= 1'b0;
            end
            if (tc && dir) begin
                r_unf <= 1'b1;
            end else if (clr_status) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign ovf = r_ovf;
    assign unf = r_unf;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_status;
    assign ovf          = 1'b0;
    assign unf          = 1'b0;
`endif

endmodule
